// File: rtl/ras_pkg.sv
// ras_pkg: shared definitions for the return address stack.
//   - Default sizing constants (stack depth, address width, recursion counter width).
//   - ras_op_e: the request type, decoded from the push/pop request pair.
//   - ras_decode(): maps a push/pop pair onto ras_op_e.
// The counter width constant only matters when RAS_COUNTER_EN is defined.
package ras_pkg;

    localparam int unsigned RasSizeDefault         = 8;
    localparam int unsigned AddrWidthDefault       = 32;
    localparam int unsigned RasCounterWidthDefault = 4;

    // OpSwap is a simultaneous push+pop (context switch).
    typedef enum logic [1:0] {
        OpIdle,
        OpPush,
        OpPop,
        OpSwap
    } ras_op_e;

    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        ras_op_e op;
        case ({push, pop})
            2'b10:   op = OpPush;
            2'b01:   op = OpPop;
            2'b11:   op = OpSwap;
            default: op = OpIdle;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ras.sv
// ras: return address stack for the branch predictor.
//   A circular LIFO of return addresses. A push on a full stack silently overwrites the oldest
//   entry. The predicted target is the entry at the top pointer and is read combinationally, so
//   a pop or replace in the same cycle sees the pre-update top.
// Optional feature, macro RAS_COUNTER_EN: each entry carries a recursion counter, so repeated
//   pushes of the same address share one entry instead of consuming stack depth.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset; wins over any request in the same cycle
//   bp_ras_addr  in   return address to push (fetch pc + 4)
//   bp_ras_push  in   push request (call / context switch)
//   bp_ras_pop   in   pop request (return / context switch)
//   ras_bp_addr  out  predicted return target = entry at the top pointer
module ras
    import ras_pkg::*;
#(
    parameter int unsigned RAS_DEPTH      = RasSizeDefault,
    parameter int unsigned RAS_ADDR_WIDTH = AddrWidthDefault
`ifdef RAS_COUNTER_EN
    ,
    parameter int unsigned RAS_CNT_WIDTH  = RasCounterWidthDefault
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RAS_ADDR_WIDTH-1:0] bp_ras_addr,
    input  logic                      bp_ras_push,
    input  logic                      bp_ras_pop,
    output logic [RAS_ADDR_WIDTH-1:0] ras_bp_addr
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam logic [PtrW:0] UsedFull = RAS_DEPTH[PtrW:0];

    typedef struct packed {
        logic [RAS_ADDR_WIDTH-1:0] addr;
`ifdef RAS_COUNTER_EN
        logic [RAS_CNT_WIDTH-1:0]  cnt;
`endif
    } entry_t;

    entry_t          buf_q [RAS_DEPTH];
    entry_t          buf_d [RAS_DEPTH];
    logic [PtrW-1:0] top_q, top_d;
    logic [PtrW:0]   used_q, used_d;

    ras_op_e         op;
    logic            empty;
    entry_t          top_entry;
    logic [PtrW-1:0] top_inc, top_dec;

    // Actions chosen by the request decode, applied afterwards in one place.
    logic            do_push, do_pop, do_replace;
`ifdef RAS_COUNTER_EN
    logic            cnt_inc, cnt_dec;
`endif

    assign op        = ras_decode(bp_ras_push, bp_ras_pop);
    assign empty     = (used_q == '0);
    assign top_entry = buf_q[top_q];
    // Depth is a power of two, so natural pointer overflow gives the circular wrap.
    assign top_inc   = top_q + 1'b1;
    assign top_dec   = top_q - 1'b1;

    assign ras_bp_addr = top_entry.addr;

    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
`ifdef RAS_COUNTER_EN
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
`endif
        case (op)
            OpPush: begin
`ifdef RAS_COUNTER_EN
                // Recursive call to the same return site: count it instead of stacking it.
                if (!empty && bp_ras_addr == top_entry.addr && top_entry.cnt != '1) begin
                    cnt_inc = 1'b1;
                end else begin
                    do_push = 1'b1;
                end
`else
                do_push = 1'b1;
`endif
            end
            OpPop: begin
                // A pop on an empty stack is dropped so the pointer cannot underflow.
                if (!empty) begin
`ifdef RAS_COUNTER_EN
                    if (top_entry.cnt != '0) begin
                        cnt_dec = 1'b1;
                    end else begin
                        do_pop = 1'b1;
                    end
`else
                    do_pop = 1'b1;
`endif
                end
            end
            OpSwap: begin
                if (empty) begin
                    do_push = 1'b1;
                end else begin
`ifdef RAS_COUNTER_EN
                    // A counted entry still has live returns: keep it and stack the new one.
                    if (top_entry.cnt != '0) begin
                        cnt_dec = 1'b1;
                        do_push = 1'b1;
                    end else begin
                        do_replace = 1'b1;
                    end
`else
                    do_replace = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        buf_d  = buf_q;
        top_d  = top_q;
        used_d = used_q;

`ifdef RAS_COUNTER_EN
        if (cnt_inc) begin
            buf_d[top_q].cnt = top_entry.cnt + 1'b1;
        end
        if (cnt_dec) begin
            buf_d[top_q].cnt = top_entry.cnt - 1'b1;
        end
`endif

        if (do_push) begin
            top_d               = top_inc;
            buf_d[top_inc].addr = bp_ras_addr;
`ifdef RAS_COUNTER_EN
            buf_d[top_inc].cnt  = '0;
`endif
            // When full the write lands on the oldest entry; the count saturates.
            used_d = (used_q == UsedFull) ? used_q : used_q + 1'b1;
        end

        if (do_pop) begin
            top_d  = top_dec;
            used_d = used_q - 1'b1;
        end

        if (do_replace) begin
            buf_d[top_q].addr = bp_ras_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            top_q  <= '0;
            used_q <= '0;
        end else begin
            buf_q  <= buf_d;
            top_q  <= top_d;
            used_q <= used_d;
        end
    end

endmodule

// File: tb/tb_ras.sv
// tb_ras: directed self-checking bench for ras (default parameters).
//   Observes ras_bp_addr plus the internal occupancy count and top pointer.
module tb_ras;

    logic        clk;
    logic        rst;
    logic [31:0] bp_ras_addr;
    logic        bp_ras_push;
    logic        bp_ras_pop;
    logic [31:0] ras_bp_addr;

    int n_checks = 0;
    int n_fail   = 0;

    ras dut (
        .clk        (clk),
        .rst        (rst),
        .bp_ras_addr(bp_ras_addr),
        .bp_ras_push(bp_ras_push),
        .bp_ras_pop (bp_ras_pop),
        .ras_bp_addr(ras_bp_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock with the given request held across the rising edge; returns #1 after it.
    task automatic cycle(input logic r, input logic push, input logic pop,
                         input logic [31:0] addr);
        rst         = r;
        bp_ras_push = push;
        bp_ras_pop  = pop;
        bp_ras_addr = addr;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bp_ras_push = 1'b0;
        bp_ras_pop  = 1'b0;
        bp_ras_addr = '0;
    endtask

    task automatic check_used(input string tag, input logic [31:0] exp);
        check_val(tag, 32'(dut.used_q), exp);
    endtask

    initial begin
        rst         = 1'b1;
        bp_ras_push = 1'b0;
        bp_ras_pop  = 1'b0;
        bp_ras_addr = '0;

        // Reset, then idle.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("reset_addr", ras_bp_addr, 32'h0);
        check_used("reset_used", 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("idle_addr", ras_bp_addr, 32'h0);

        // Pop on empty is ignored.
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_val("empty_pop_addr", ras_bp_addr, 32'h0);
        check_used("empty_pop_used", 32'd0);
        check_val("empty_pop_top", 32'(dut.top_q), 32'd0);

        // Two pushes, two pops (each pop reads the pre-update top).
        cycle(1'b0, 1'b1, 1'b0, 32'h8010_0024);
        cycle(1'b0, 1'b1, 1'b0, 32'h8010_0044);
        check_val("push2_addr", ras_bp_addr, 32'h8010_0044);
        check_used("push2_used", 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_val("pop1_addr", ras_bp_addr, 32'h8010_0024);
        check_used("pop1_used", 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_used("pop2_used", 32'd0);
        check_val("pop2_stale_addr", ras_bp_addr, 32'h0);

        // Push then push+pop replaces in place.
        cycle(1'b0, 1'b1, 1'b0, 32'h8010_0024);
        cycle(1'b0, 1'b1, 1'b1, 32'h80aa_bbc0);
        check_val("swap_addr", ras_bp_addr, 32'h80aa_bbc0);
        check_used("swap_used", 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_used("swap_pop_used", 32'd0);
        check_val("swap_pop_addr", ras_bp_addr, 32'h0);

        // Push+pop on empty acts as a push.
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_7770);
        check_val("swap_empty_addr", ras_bp_addr, 32'h0000_7770);
        check_used("swap_empty_used", 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Overflow: 10 pushes into 8 entries, then 8 pops, then ignored pops.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h1000 + 32'(4 * i));
        end
        check_val("ovf_top_addr", ras_bp_addr, 32'h1024);
        check_used("ovf_used", 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("ovf_pop%0d_addr", i), ras_bp_addr, 32'h1024 - 32'(4 * i));
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
        end
        check_used("ovf_drained_used", 32'd0);
        // Pointer is back on the slot holding the newest write.
        check_val("ovf_drained_addr", ras_bp_addr, 32'h1024);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check_val("ovf_ignored_addr", ras_bp_addr, 32'h1024);
        check_used("ovf_ignored_used", 32'd0);

        // Reset wins over a push in the same cycle.
        cycle(1'b1, 1'b1, 1'b0, 32'h5550);
        check_val("rst_push_addr", ras_bp_addr, 32'h0);
        check_used("rst_push_used", 32'd0);

        // Repeated push of one address.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h2000);
        end
        check_val("dup_addr", ras_bp_addr, 32'h2000);
`ifdef RAS_COUNTER_EN
        check_used("dup_used", 32'd1);
`else
        check_used("dup_used", 32'd3);
`endif
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("dup_pop%0d_addr", i), ras_bp_addr, 32'h2000);
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
        end
        check_used("dup_empty_used", 32'd0);
        check_val("dup_empty_addr", ras_bp_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
